seg7_rotation_monitor: RTL and testbench

- Receive-side checker for a rotating seven-segment digit stream (segment byte dp|g|f|e|d|c|b|a, active-high).
- Samples the segment bus and filters out transient patterns. Decodes each accepted pattern back to a BCD digit.
- Flags illegal codes, and flags sequence breaks where a digit is not the previous digit +1 mod 10.
- Sits on the display bus as a bench/on-chip monitor; keeps a saturating error count.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_stable_filter.sv | 58 +++++
 rtl/seg7_rotation_monitor.sv | 110 +++++++++++
 tb/tb_seg7_rotation_monitor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants, lock states and pattern decoder
package seg7_pkg;

    localparam logic [7:0] SEG7_0     = 8'h3f;
    localparam logic [7:0] SEG7_1     = 8'h06;
    localparam logic [7:0] SEG7_2     = 8'h5b;
    localparam logic [7:0] SEG7_3     = 8'h4f;
    localparam logic [7:0] SEG7_4     = 8'h66;
    localparam logic [7:0] SEG7_5     = 8'h6d;
    localparam logic [7:0] SEG7_6     = 8'h7c;
    localparam logic [7:0] SEG7_7     = 8'h07;
    localparam logic [7:0] SEG7_8     = 8'h7f;
    localparam logic [7:0] SEG7_9     = 8'h6f;
    localparam logic [7:0] SEG7_6_ALT = 8'h7d;
    localparam logic [7:0] SEG7_BLANK = 8'h00;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg7_dec_t;

    // Blank (00) decodes as not legal; callers tell it apart from illegal codes.
    function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
        seg7_dec_t r_dec;
        r_dec = '0;
        case ({1'b0, pattern})
            SEG7_0:     r_dec = '{legal: 1'b1, value: 4'd0};
            SEG7_1:     r_dec = '{legal: 1'b1, value: 4'd1};
            SEG7_2:     r_dec = '{legal: 1'b1, value: 4'd2};
            SEG7_3:     r_dec = '{legal: 1'b1, value: 4'd3};
            SEG7_4:     r_dec = '{legal: 1'b1, value: 4'd4};
            SEG7_5:     r_dec = '{legal: 1'b1, value: 4'd5};
            SEG7_6:     r_dec = '{legal: 1'b1, value: 4'd6};
            SEG7_6_ALT: r_dec = '{legal: 1'b1, value: 4'd6};
            SEG7_7:     r_dec = '{legal: 1'b1, value: 4'd7};
            SEG7_8:     r_dec = '{legal: 1'b1, value: 4'd8};
            SEG7_9:     r_dec = '{legal: 1'b1, value: 4'd9};
            default:    r_dec = '0;
        endcase
        return r_dec;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// rtl/seg7_stable_filter.sv - debounce the g..a segment pattern and strobe each newly accepted pattern
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_pattern,
    output logic       o_accept,
    output logic [6:0] o_pattern
);

    localparam int            CW  = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [6:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_acc_pat;

    logic          w_change;
    logic [CW-1:0] w_cnt_next;
    logic          w_reached;
    logic          w_accept;

    always_comb begin
        w_change = (i_pattern != r_cand);
        if (w_change) begin
            w_cnt_next = ONE;
        end else if (r_cnt == SAT) begin
            w_cnt_next = SAT;
        end else begin
            w_cnt_next = r_cnt + ONE;
        end
        // Fire only on the edge the count arrives at SAT, not while it sits there.
        w_reached = (w_cnt_next == SAT) && (w_change || (r_cnt != SAT));
        w_accept  = w_reached && (i_pattern != r_acc_pat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand    <= 7'h00;
            r_cnt     <= SAT;
            r_acc_pat <= 7'h00;
        end else begin
            r_cand <= i_pattern;
            r_cnt  <= w_cnt_next;
            if (w_accept) begin
                r_acc_pat <= i_pattern;
            end
        end
    end

    assign o_accept  = w_accept;
    assign o_pattern = i_pattern;

endmodule

// File: rtl/seg7_rotation_monitor.sv
// rtl/seg7_rotation_monitor.sv - rotating seven-segment digit checker with code/sequence error counting
module seg7_rotation_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             dp_out,
    output logic             blank,
    output logic             code_err,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    logic        w_accept;
    logic [6:0]  w_pat;
    seg7_dec_t   w_dec;
    logic        w_blank_pat;
    logic [3:0]  w_expected;
    logic        w_code_err;
    logic        w_seq_err;
    lock_state_t r_lock_state;
    lock_state_t w_lock_next;

    logic [3:0]       r_digit;
    logic             r_digit_valid;
    logic             r_dp;
    logic             r_blank;
    logic             r_code_err;
    logic             r_seq_err;
    logic [CNT_W-1:0] r_err_count;

    seg7_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .i_pattern(seg_in[6:0]),
        .o_accept (w_accept),
        .o_pattern(w_pat)
    );

    always_comb begin
        w_dec       = seg7_decode(w_pat);
        w_blank_pat = (w_pat == SEG7_BLANK[6:0]);
        w_expected  = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        w_lock_next = r_lock_state;
        w_code_err  = 1'b0;
        w_seq_err   = 1'b0;
        if (w_accept) begin
            if (w_dec.legal) begin
                w_seq_err   = (r_lock_state == LOCK_LOCKED) && (w_dec.value != w_expected);
                w_lock_next = LOCK_LOCKED;
            end else if (!w_blank_pat) begin
                w_code_err  = 1'b1;
                w_lock_next = LOCK_UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state <= LOCK_UNLOCKED;
        end else begin
            r_lock_state <= w_lock_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_dp          <= 1'b0;
            r_blank       <= 1'b1;
            r_code_err    <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_digit_valid <= w_accept && w_dec.legal;
            r_code_err    <= w_code_err;
            r_seq_err     <= w_seq_err;
            if (w_accept) begin
                r_dp    <= seg_in[7];
                r_blank <= w_blank_pat;
                if (w_dec.legal) begin
                    r_digit <= w_dec.value;
                end
            end
            if ((w_code_err || w_seq_err) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign dp_out      = r_dp;
    assign blank       = r_blank;
    assign code_err    = r_code_err;
    assign seq_err     = r_seq_err;
    assign locked      = (r_lock_state == LOCK_LOCKED);
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_seg7_rotation_monitor.sv
// tb/tb_seg7_rotation_monitor.sv - directed scoreboard bench for seg7_rotation_monitor
module tb_seg7_rotation_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_in = 8'h00;

    always #5 clk = ~clk;

    // Instance a: STABLE_CYCLES=1, CNT_W=16
    logic [3:0]  a_digit;
    logic        a_dv, a_dp, a_blank, a_ce, a_se, a_lk;
    logic [15:0] a_ec;
    // Instance b: STABLE_CYCLES=1, CNT_W=2
    logic [3:0]  b_digit;
    logic        b_dv, b_dp, b_blank, b_ce, b_se, b_lk;
    logic [1:0]  b_ec;
    // Instance c: STABLE_CYCLES=3, CNT_W=16
    logic [3:0]  c_digit;
    logic        c_dv, c_dp, c_blank, c_ce, c_se, c_lk;
    logic [15:0] c_ec;

    seg7_rotation_monitor #(.STABLE_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_in), .digit(a_digit), .digit_valid(a_dv),
        .dp_out(a_dp), .blank(a_blank), .code_err(a_ce), .seq_err(a_se),
        .locked(a_lk), .err_count(a_ec)
    );
    seg7_rotation_monitor #(.STABLE_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_in), .digit(b_digit), .digit_valid(b_dv),
        .dp_out(b_dp), .blank(b_blank), .code_err(b_ce), .seq_err(b_se),
        .locked(b_lk), .err_count(b_ec)
    );
    seg7_rotation_monitor #(.STABLE_CYCLES(3), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .seg_in(seg_in), .digit(c_digit), .digit_valid(c_dv),
        .dp_out(c_dp), .blank(c_blank), .code_err(c_ce), .seq_err(c_se),
        .locked(c_lk), .err_count(c_ec)
    );

    typedef struct packed {
        logic [3:0]  digit;
        logic        dv;
        logic        dp;
        logic        blank;
        logic        ce;
        logic        se;
        logic        lk;
        logic [15:0] ec;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   sel   = 0;

    function automatic obs_t mk(input int d, input int dv, input int dp, input int bl,
                                input int ce, input int se, input int lk, input int ec);
        obs_t r;
        r.digit = 4'(d);
        r.dv    = 1'(dv);
        r.dp    = 1'(dp);
        r.blank = 1'(bl);
        r.ce    = 1'(ce);
        r.se    = 1'(se);
        r.lk    = 1'(lk);
        r.ec    = 16'(ec);
        return r;
    endfunction

    function automatic obs_t observe(input int which);
        obs_t r;
        case (which)
            1:       r = '{b_digit, b_dv, b_dp, b_blank, b_ce, b_se, b_lk, {14'd0, b_ec}};
            2:       r = '{c_digit, c_dv, c_dp, c_blank, c_ce, c_se, c_lk, c_ec};
            default: r = '{a_digit, a_dv, a_dp, a_blank, a_ce, a_se, a_lk, a_ec};
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input int which);
        obs_t e;
        obs_t o;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            o = observe(which);
            assert (o === e) else begin
                bad++;
                $error("FAIL %s dut=%0d observed=%h expected=%h", tag, which, o, e);
            end
        end
    endtask

    task automatic step(input logic [7:0] s, input obs_t e, input string tag);
        @(negedge clk);
        seg_in = s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag, sel);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst    = 1'b1;
        seg_in = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
            check(tag, k);
        end
    endtask

    logic [7:0] pat [10];

    initial begin
        pat = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7c, 8'h07, 8'h7f, 8'h6f};

        // Full rotation with a held 9 and wrap to 0
        sel = 0;
        do_reset("reset_init");
        for (int i = 0; i < 10; i++) step(pat[i], mk(i, 1, 0, 0, 0, 0, 1, 0), "rotate");
        repeat (7) step(8'h6f, mk(9, 0, 0, 0, 0, 0, 1, 0), "hold9");
        step(8'h3f, mk(0, 1, 0, 0, 0, 0, 1, 0), "wrap");

        // Illegal code unlocks, next legal digit resyncs without a sequence check
        step(8'h06, mk(1, 1, 0, 0, 0, 0, 1, 0), "b1");
        step(8'h5b, mk(2, 1, 0, 0, 0, 0, 1, 0), "b2");
        step(8'h4f, mk(3, 1, 0, 0, 0, 0, 1, 0), "b3");
        step(8'h49, mk(3, 0, 0, 0, 1, 0, 0, 1), "illegal");
        step(8'h66, mk(4, 1, 0, 0, 0, 0, 1, 1), "resync");
        step(8'h6d, mk(5, 1, 0, 0, 0, 0, 1, 1), "b5");
        step(8'h7d, mk(6, 1, 0, 0, 0, 0, 1, 1), "alt6");

        // Skipped digit, dp-only change, mid-stream reset
        do_reset("reset_seq");
        step(8'h06, mk(1, 1, 0, 0, 0, 0, 1, 0), "c1");
        step(8'h5b, mk(2, 1, 0, 0, 0, 0, 1, 0), "c2");
        step(8'h66, mk(4, 1, 0, 0, 0, 1, 1, 1), "skip3");
        step(8'h6d, mk(5, 1, 0, 0, 0, 0, 1, 1), "after_skip");
        step(8'hed, mk(5, 0, 0, 0, 0, 0, 1, 1), "dp_only");
        do_reset("reset_mid");
        step(8'hff, mk(8, 1, 1, 0, 0, 0, 1, 0), "post_reset");

        // STABLE_CYCLES=3 glitch rejection
        sel = 2;
        do_reset("reset_st3");
        step(8'h3f, mk(0, 0, 0, 1, 0, 0, 0, 0), "st3_0a");
        step(8'h3f, mk(0, 0, 0, 1, 0, 0, 0, 0), "st3_0b");
        step(8'h3f, mk(0, 1, 0, 0, 0, 0, 1, 0), "st3_0c");
        step(8'h06, mk(0, 0, 0, 0, 0, 0, 1, 0), "glitch");
        step(8'h3f, mk(0, 0, 0, 0, 0, 0, 1, 0), "back0");
        step(8'h06, mk(0, 0, 0, 0, 0, 0, 1, 0), "st3_1a");
        step(8'h06, mk(0, 0, 0, 0, 0, 0, 1, 0), "st3_1b");
        step(8'h06, mk(1, 1, 0, 0, 0, 0, 1, 0), "st3_1c");

        // CNT_W=2 saturation and blank
        sel = 1;
        do_reset("reset_sat");
        step(8'h49, mk(0, 0, 0, 0, 1, 0, 0, 1), "sat1");
        step(8'h12, mk(0, 0, 0, 0, 1, 0, 0, 2), "sat2");
        step(8'h49, mk(0, 0, 0, 0, 1, 0, 0, 3), "sat3");
        step(8'h12, mk(0, 0, 0, 0, 1, 0, 0, 3), "sat4");
        step(8'h49, mk(0, 0, 0, 0, 1, 0, 0, 3), "sat5");
        step(8'h00, mk(0, 0, 0, 1, 0, 0, 0, 3), "blank");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
